// File: rtl/seq_detect_pkg.sv
// Shared definitions for the "1011" sequence-detector scheduler: state
// encoding, the reference pattern, and recovery of undefined state codes.
package seq_detect_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  localparam logic [3:0] PATTERN       = 4'b1011;
  localparam state_t     RECOVER_STATE = S0;

  // Codes 101..111 are unreachable in normal operation; fold them back to idle.
  function automatic state_t decode_state(input logic [2:0] code);
    case (code)
      3'b000:  return S0;
      3'b001:  return S1;
      3'b010:  return S2;
      3'b011:  return S3;
      3'b100:  return S4;
      default: return RECOVER_STATE;
    endcase
  endfunction

endpackage

// File: rtl/seq_detect_core.sv
// Combinational next-state core of the "1011" Moore detector, shared by all
// channels through the scheduler's grant mux.
import seq_detect_pkg::*;

module seq_detect_core (
  input  logic [2:0] state_in,
  input  logic       bit_in,
  output logic [2:0] state_out,
  output logic       hit
);

  state_t cur;
  state_t nxt;

  always_comb begin
    cur = decode_state(state_in);
    nxt = RECOVER_STATE;
    case (cur)
      S0:      nxt = bit_in ? S1 : S0;
      S1:      nxt = bit_in ? S1 : S2;
      S2:      nxt = bit_in ? S3 : S0;
      S3:      nxt = bit_in ? S4 : S2;
      S4:      nxt = bit_in ? S1 : S2;
      default: nxt = RECOVER_STATE;
    endcase
  end

  assign state_out = nxt;
  assign hit       = (nxt == S4);

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one sequence-detector core among NCH serial
// channels; per-channel state bank, registered hit report, saturating count.
import seq_detect_pkg::*;

module seq_detect_sched #(
  parameter int NCH  = 4,
  parameter int CW   = $clog2(NCH),
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  bit_in,
  input  logic [NCH-1:0]  clr,
  output logic [NCH-1:0]  ack,
  output logic [NCH-1:0]  det,
  output logic            hit_valid,
  output logic [CW-1:0]   hit_ch,
  output logic [CNTW-1:0] hit_cnt
);

  logic [NCH-1:0] elig;
  logic [NCH-1:0] grant;
  logic           gnt_vld;
  logic [CW-1:0]  gnt_idx;
  logic [CW-1:0]  ptr;
  logic [2:0]     state [NCH];
  logic [2:0]     core_in;
  logic [2:0]     core_out;
  logic           core_bit;
  logic           core_hit;

  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) s = s - NCH;
    return CW'(s);
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // A cleared channel is excluded so its offered bit stays pending.
  assign elig = req & ~clr;

  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!gnt_vld && elig[wrap_idx(ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_idx(ptr, k);
      end
    end
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  assign ack = rst ? '0 : grant;

  assign core_in  = state[gnt_idx];
  assign core_bit = bit_in[gnt_idx];

  seq_detect_core u_core (
    .state_in  (core_in),
    .bit_in    (core_bit),
    .state_out (core_out),
    .hit       (core_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) state[i] <= S0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i])        state[i] <= S0;
        else if (grant[i]) state[i] <= core_out;
      end
    end
  end

  always_comb begin
    det = '0;
    for (int i = 0; i < NCH; i++) det[i] = (state[i] == S4);
  end

  // Grant edge: pointer advance, hit report and counter all register together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      hit_valid <= 1'b0;
      hit_ch    <= '0;
      hit_cnt   <= '0;
    end else begin
      hit_valid <= gnt_vld && core_hit;
      if (gnt_vld) begin
        ptr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
        if (core_hit) begin
          hit_ch  <= gnt_idx;
          hit_cnt <= sat_inc(hit_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench for seq_detect_sched: directed scenarios plus a random
// run against a suffix-matching reference model.
import seq_detect_pkg::*;

module tb_seq_detect_sched;

  localparam int NCH  = 4;
  localparam int CW   = 2;
  localparam int CNTW = 4;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  req, bit_in, clr;
  logic [NCH-1:0]  ack, det;
  logic            hit_valid;
  logic [CW-1:0]   hit_ch;
  logic [CNTW-1:0] hit_cnt;

  seq_detect_sched #(.NCH(NCH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .clr(clr),
    .ack(ack), .det(det), .hit_valid(hit_valid), .hit_ch(hit_ch), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a channel is "detected" when the last four bits it has
  // consumed since its last clear/reset spell the pattern.
  int             m_ptr;
  logic [3:0]     m_hist [NCH];
  int             m_len  [NCH];
  int             m_cnt;
  int             exp_hch;
  logic           exp_hv;
  logic [NCH-1:0] exp_ack, obs_ack, exp_det;
  logic [3:0]     pat;

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; exp_hch = 0; exp_hv = 1'b0; exp_det = '0;
    for (int i = 0; i < NCH; i++) begin m_hist[i] = '0; m_len[i] = 0; end
  endtask

  // Called at a negedge: drive, sample ack, advance one clock, update the model.
  task automatic apply(input logic [NCH-1:0] r, input logic [NCH-1:0] b, input logic [NCH-1:0] c);
    int g;
    req = r; bit_in = b; clr = c;
    #1;
    g = -1;
    exp_ack = '0;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (m_ptr + k) % NCH;
      if (g < 0 && r[idx] && !c[idx]) g = idx;
    end
    if (g >= 0) exp_ack[g] = 1'b1;
    obs_ack = ack;
    @(posedge clk);
    exp_hv = 1'b0;
    for (int i = 0; i < NCH; i++) if (c[i]) begin m_len[i] = 0; m_hist[i] = '0; end
    if (g >= 0) begin
      m_hist[g] = {m_hist[g][2:0], b[g]};
      m_len[g]++;
      if (m_len[g] >= 4 && m_hist[g] == PATTERN) begin
        exp_hv = 1'b1; exp_hch = g;
        if (m_cnt < CMAX) m_cnt++;
      end
      m_ptr = (g + 1) % NCH;
    end
    for (int i = 0; i < NCH; i++) exp_det[i] = (m_len[i] >= 4 && m_hist[i] == PATTERN);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; bit_in = '1; clr = '0;
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want 0000", ack); end
    n_cmp++; if (det !== 4'b0000) begin n_fail++; $display("FAIL reset_det got %b want 0000", det); end
    n_cmp++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hv got %b want 0", hit_valid); end
    n_cmp++; if (hit_ch !== 2'd0) begin n_fail++; $display("FAIL reset_hch got %0d want 0", hit_ch); end
    n_cmp++; if (hit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", hit_cnt); end
    @(negedge clk);
    rst = 1'b0; req = '0; bit_in = '0;
    model_reset();
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) begin
      apply(4'b0001, {3'b000, pat[3-k]}, 4'b0000);
      n_cmp++; if (obs_ack !== 4'b0001) begin n_fail++; $display("FAIL basic_ack step %0d got %b want 0001", k, obs_ack); end
      n_cmp++; if (hit_valid !== (k == 3)) begin n_fail++; $display("FAIL basic_hv step %0d got %b want %b", k, hit_valid, k == 3); end
    end
    n_cmp++; if (hit_ch !== 2'd0) begin n_fail++; $display("FAIL basic_hch got %0d want 0", hit_ch); end
    n_cmp++; if (det[0] !== 1'b1) begin n_fail++; $display("FAIL basic_det got %b want 1", det[0]); end
    n_cmp++; if (hit_cnt !== 4'd1) begin n_fail++; $display("FAIL basic_cnt got %0d want 1", hit_cnt); end
  endtask

  task automatic test_overlap();
    logic [6:0] seq;
    int pulses;
    seq = 7'b1011011;
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      apply(4'b0100, {1'b0, seq[6-k], 2'b00}, 4'b0000);
      n_cmp++; if (hit_valid !== (k == 3 || k == 6)) begin n_fail++; $display("FAIL overlap_hv step %0d got %b", k, hit_valid); end
      if (hit_valid) begin
        pulses++;
        n_cmp++; if (hit_ch !== 2'd2) begin n_fail++; $display("FAIL overlap_hch got %0d want 2", hit_ch); end
      end
    end
    n_cmp++; if (pulses != 2) begin n_fail++; $display("FAIL overlap_pulses got %0d want 2", pulses); end
    n_cmp++; if (hit_cnt !== 4'd3) begin n_fail++; $display("FAIL overlap_cnt got %0d want 3", hit_cnt); end
  endtask

  task automatic test_fairness();
    int c1, pulses;
    apply(4'b1000, 4'b0000, 4'b0111);
    n_cmp++; if (obs_ack !== 4'b1000) begin n_fail++; $display("FAIL fair_pre_ack got %b want 1000", obs_ack); end
    c1 = 0; pulses = 0;
    for (int k = 0; k < 16; k++) begin
      apply(4'b1111, {2'b00, pat[3 - (c1 > 3 ? 3 : c1)], 1'b0}, 4'b0000);
      n_cmp++; if (obs_ack !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL fair_ack cyc %0d got %b want %b", k, obs_ack, 4'b0001 << (k % 4)); end
      if (obs_ack[1]) c1++;
      if (hit_valid) begin
        pulses++;
        n_cmp++; if (hit_ch !== 2'd1 || k != 13) begin n_fail++; $display("FAIL fair_hit cyc %0d ch %0d want cyc 13 ch 1", k, hit_ch); end
      end
    end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL fair_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_clear_conflict();
    apply(4'b1000, 4'b1000, 4'b0000);
    apply(4'b1000, 4'b0000, 4'b0000);
    apply(4'b1000, 4'b1000, 4'b0000);
    apply(4'b1000, 4'b1000, 4'b1000);
    n_cmp++; if (obs_ack !== 4'b0000) begin n_fail++; $display("FAIL clr_ack got %b want 0000", obs_ack); end
    n_cmp++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL clr_hv got %b want 0", hit_valid); end
    n_cmp++; if (det[3] !== 1'b0) begin n_fail++; $display("FAIL clr_det got %b want 0", det[3]); end
    apply(4'b1000, 4'b1000, 4'b0000);
    n_cmp++; if (obs_ack !== 4'b1000 || hit_valid !== 1'b0) begin n_fail++; $display("FAIL clr_reoffer ack %b hv %b want 1000/0", obs_ack, hit_valid); end
    apply(4'b1000, 4'b0000, 4'b0000);
    apply(4'b1000, 4'b1000, 4'b0000);
    n_cmp++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL clr_s3_hv got %b want 0", hit_valid); end
    apply(4'b1000, 4'b1000, 4'b0000);
    n_cmp++; if (hit_valid !== 1'b1 || hit_ch !== 2'd3) begin n_fail++; $display("FAIL clr_s1_hit hv %b ch %0d want 1/3", hit_valid, hit_ch); end
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    apply(4'b0000, 4'b0000, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      apply(4'b0001, {3'b000, pat[3-k]}, 4'b0000);
      if (hit_valid) pulses++;
    end
    for (int h = 0; h < 19; h++) begin
      apply(4'b0001, 4'b0000, 4'b0000); if (hit_valid) pulses++;
      apply(4'b0001, 4'b0001, 4'b0000); if (hit_valid) pulses++;
      apply(4'b0001, 4'b0001, 4'b0000); if (hit_valid) pulses++;
    end
    n_cmp++; if (pulses != 20) begin n_fail++; $display("FAIL sat_pulses got %0d want 20", pulses); end
    n_cmp++; if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL sat_last_hv got %b want 1", hit_valid); end
    n_cmp++; if (hit_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_cnt got %h want f", hit_cnt); end
  endtask

  task automatic test_async_reset();
    apply(4'b0000, 4'b0000, 4'b0010);
    apply(4'b0010, 4'b0010, 4'b0000);
    apply(4'b0010, 4'b0000, 4'b0000);
    apply(4'b0010, 4'b0010, 4'b0000);
    req = 4'b0010; bit_in = 4'b0010; clr = '0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL arst_ack got %b want 0000", ack); end
    n_cmp++; if (det !== 4'b0000 || hit_valid !== 1'b0) begin n_fail++; $display("FAIL arst_det_hv got %b/%b want 0000/0", det, hit_valid); end
    n_cmp++; if (hit_cnt !== 4'd0 || hit_ch !== 2'd0) begin n_fail++; $display("FAIL arst_cnt_ch got %0d/%0d want 0/0", hit_cnt, hit_ch); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply(4'b0010, 4'b0010, 4'b0000);
    n_cmp++; if (obs_ack !== 4'b0010 || hit_valid !== 1'b0 || det[1] !== 1'b0) begin n_fail++; $display("FAIL arst_restart ack %b hv %b det %b", obs_ack, hit_valid, det[1]); end
    apply(4'b0010, 4'b0000, 4'b0000);
    apply(4'b0010, 4'b0010, 4'b0000);
    apply(4'b0010, 4'b0010, 4'b0000);
    n_cmp++; if (hit_valid !== 1'b1 || hit_cnt !== 4'd1) begin n_fail++; $display("FAIL arst_rehit hv %b cnt %0d want 1/1", hit_valid, hit_cnt); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] r, b, c;
    r = '0; b = '0; obs_ack = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!(r[i] && !obs_ack[i])) begin
          r[i] = 1'($urandom_range(0, 1));
          b[i] = 1'($urandom_range(0, 1));
        end
        c[i] = ($urandom_range(0, 7) == 0);
      end
      apply(r, b, c);
      n_cmp++; if (obs_ack !== exp_ack) begin n_fail++; $display("FAIL rand_ack cyc %0d got %b want %b", k, obs_ack, exp_ack); end
      n_cmp++; if (hit_valid !== exp_hv) begin n_fail++; $display("FAIL rand_hv cyc %0d got %b want %b", k, hit_valid, exp_hv); end
      if (exp_hv) begin
        n_cmp++; if (hit_ch !== 2'(exp_hch)) begin n_fail++; $display("FAIL rand_hch cyc %0d got %0d want %0d", k, hit_ch, exp_hch); end
      end
      n_cmp++; if (det !== exp_det) begin n_fail++; $display("FAIL rand_det cyc %0d got %b want %b", k, det, exp_det); end
      n_cmp++; if (hit_cnt !== 4'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", k, hit_cnt, m_cnt); end
    end
  endtask

  initial begin
    pat = PATTERN;
    rst = 1'b1; req = '0; bit_in = '0; clr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_overlap();
    test_fairness();
    test_clear_conflict();
    test_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Time-multiplexed scheduler that shares one "1011" Moore sequence-detector next-state core among NCH serial bit-stream requesters. Each channel keeps its own 3-bit detector state in a register bank. A round-robin arbiter grants at most one channel per cycle, steps that channel's state through the shared core, and reports detections. The block sits between the serial front-end channels and the event/interrupt logic.

## Interface
- NCH, 4, number of requester channels (2..16)
- CW, $clog2(NCH), channel index width (derived; do not override)
- CNTW, 16, width of the saturating hit counter
- clk  input  1  clock; all flops rise-edge
- rst  input  1  reset rst, asynchronous, active-high
- req  input  NCH  per-channel request: a bit is offered this cycle
- bit_in  input  NCH  per-channel serial bit, valid when the matching req is high
- clr  input  NCH  per-channel synchronous clear of detector state to S0
- ack  output  NCH  one-hot grant, combinational; the offered bit is consumed at this edge
- det  output  NCH  per-channel level, high while that channel's state is S4
- hit_valid  output  1  registered single-cycle pulse; a grant caused a transition into S4
- hit_ch  output  CW  channel index of the hit; valid with hit_valid
- hit_cnt  output  CNTW  total hits since reset; saturating

## Operation
- Detector states (shared package): S0=000 idle, S1=001 "1", S2=010 "10", S3=011 "101", S4=100 "1011" detected.
- Next-state function:
  - S0: 1→S1, 0→S0
  - S1: 1→S1, 0→S2
  - S2: 1→S3, 0→S0
  - S3: 1→S4, 0→S2
  - S4: 1→S1, 0→S2
  - Undefined codes (101..111) → S0.
- Detection overlaps: after a hit, "011" produces the next hit.
- Eligible set is req & ~clr.
- Round-robin arbitration:
  - The search starts at pointer ptr and picks the first eligible index ascending, with wrap-around.
  - On a grant, ptr ← granted index + 1 (mod NCH). With no grant, ptr holds.
- Granted channel g: state[g] ← core(state[g], bit_in[g]). Non-granted channels hold state.
- clr[i] forces state[i] ← S0 at the edge.
  - clr takes priority; a channel with clr set is never granted that cycle, so no ack and its bit is not consumed.
- hit_valid is asserted when the granted channel's next state is S4.
- hit_cnt increments by 1 per hit and saturates at all-ones (0xFFFF at default width). Only rst clears it.
- A requester whose req is high and ack is low must hold req and bit_in until it sees ack.

## Timing
- Reset values: every state = S0, ptr = 0, det = 0, hit_valid = 0, hit_ch = 0, hit_cnt = 0. ack = 0 whenever rst is high.
- ack has zero latency: combinational from req, clr and ptr in the same cycle.
- State update: at the edge where ack[g] is high. det[g] reflects the new state in the following cycle.
- hit_valid and hit_ch: registered at the same edge as the state update, so they are visible 1 cycle after ack. hit_cnt updates at that edge too.
- Throughput: one bit per cycle in aggregate. With all NCH channels requesting continuously, each is served once every NCH cycles.
- Reset mid-stream: all partial matches are lost and the channel restarts from S0. An in-flight hit_valid is dropped.
- A single requester is granted every cycle regardless of ptr.

## Structure
- Shared package seq_detect_pkg holds:
  - the state encoding (typedef of a 3-bit enum: S0..S4)
  - localparam PATTERN = 4'b1011 for documentation and bench use
  - a function/constant for undefined-state recovery
- Sub-module seq_detect_core: purely combinational. Inputs: state_in[2:0], bit_in. Outputs: state_out[2:0], hit (state_out == S4). Instantiated once, fed through a NCH:1 mux on the granted index.
- Top level holds the arbiter, the ptr register, the state bank, the hit registers and the counter.

## Test plan
- Reset, then channel 0 alone drives 1,0,1,1 on consecutive cycles → ack[0] high every cycle; hit_valid = 1 with hit_ch = 0 exactly 1 cycle after the 4th ack; det[0] = 1; hit_cnt = 1.
- Overlap: channel 2 drives 1,0,1,1,0,1,1 → two hit_valid pulses on channel 2 (after the 4th and 7th grant); hit_cnt = 2.
- Fairness: all 4 req held high from ptr = 0 → grant order 0,1,2,3,0,1,... Interleaved per-channel patterns are tracked independently, so channel 1 hits only on its own 1011.
- Clear conflict: channel 3 in S3 asserts req = 1, bit = 1 and clr = 1 together → ack[3] = 0, state[3] = S0, no hit. Re-offering the same 1 then gives S1.
- Saturation: force 0xFFFF hits (or CNTW = 4 with 16 hits) → hit_cnt stays at all-ones while hit_valid still pulses.
- Async reset asserted mid-pattern (channel 1 in S3, between edges) → all outputs are 0 immediately. After release, channel 1 offering 1 reaches S1 and no hit occurs.
